// File: rtl/instr_fetch_stage_if.sv
// rtl/instr_fetch_stage_if.sv - instruction memory fetch handshake between fetch stage and imem
interface instr_fetch_stage_if #(
    parameter int N = 32
);
    logic         imem_req_o;
    logic [N-1:0] imem_addr_o;
    logic         imem_ready_i;
    logic [N-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - RISC-V IF stage: PC, imem handshake, IF/ID buffer, redirect/fault (FETCH_PERF_EN adds counters)
module instr_fetch_stage #(
    parameter int           N         = 32,
    parameter logic [N-1:0] RESET_PC  = 'h0040_0000,
    parameter logic [N-1:0] NOP_INSTR = 'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_stage_if.master  imem,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [N-1:0]         redirect_pc_i,
    output logic [N-1:0]         pc_o,
    output logic [N-1:0]         pc_plus4_o,
    output logic [N-1:0]         instr_o,
    output logic                 valid_o,
    output logic                 ifid_enable_o,
    output logic                 fault_o
`ifdef FETCH_PERF_EN
    ,
    output logic [N-1:0]         fetch_count_o,
    output logic [N-1:0]         stall_count_o
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_pc;
    logic [N-1:0] r_out_pc;
    logic [N-1:0] r_out_pc4;
    logic [N-1:0] r_instr;
    logic         r_valid;

    logic [N-1:0] w_pc_plus4;
    logic         w_free;
    logic         w_run;
    logic         w_accept;

    assign w_pc_plus4 = r_pc + N'(4);
    assign w_free     = ~r_valid | ~stall_i;
    assign w_run      = (r_state == RUN);
    assign w_accept   = w_run & ~redirect_i & imem.imem_ready_i & w_free;

    assign imem.imem_req_o  = w_run;
    assign imem.imem_addr_o = r_pc;
    assign pc_o             = r_out_pc;
    assign pc_plus4_o       = r_out_pc4;
    assign instr_o          = r_instr;
    assign valid_o          = r_valid;
    assign fault_o          = (r_state == FAULT);
    assign ifid_enable_o    = ~stall_i | ~w_run;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= BOOT;
            r_pc      <= RESET_PC;
            r_out_pc  <= RESET_PC;
            r_out_pc4 <= RESET_PC + N'(4);
            r_instr   <= NOP_INSTR;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (redirect_i) begin
                        // Redirect wins over stall; misaligned target is kept in pc for debug
                        r_pc    <= redirect_pc_i;
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                        if (redirect_pc_i[1:0] != 2'b00) begin
                            r_state <= FAULT;
                        end
                    end else if (w_accept) begin
                        r_out_pc  <= r_pc;
                        r_out_pc4 <= w_pc_plus4;
                        r_instr   <= imem.imem_rdata_i;
                        r_valid   <= 1'b1;
                        r_pc      <= w_pc_plus4;
                    end else if (w_free) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end
                end
                FAULT: begin
                    r_instr <= NOP_INSTR;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= FAULT;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [N-1:0] r_fetch_cnt;
    logic [N-1:0] r_stall_cnt;

    assign fetch_count_o = r_fetch_cnt;
    assign stall_count_o = r_stall_cnt;

    // Counters only advance in RUN, so they freeze naturally once FAULT is entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (w_run) begin
            if (w_accept) begin
                if (~&r_fetch_cnt) begin
                    r_fetch_cnt <= r_fetch_cnt + N'(1);
                end
            end else if (~&r_stall_cnt) begin
                r_stall_cnt <= r_stall_cnt + N'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - table-driven self-checking bench for instr_fetch_stage
module tb_instr_fetch_stage;

    localparam logic [31:0] RST = 32'h0040_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_o, pc_plus4_o, instr_o;
    logic        valid_o, ifid_enable_o, fault_o;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, stall_count;
`endif

    int checks = 0;
    int errors = 0;

    instr_fetch_stage_if #(.N(32)) imem ();

    // Memory returns its own address as the instruction word
    assign imem.imem_rdata_i = imem.imem_addr_o;

    instr_fetch_stage dut (
        .clk           (clk),
        .reset         (reset_n),
        .imem          (imem),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .instr_o       (instr_o),
        .valid_o       (valid_o),
        .ifid_enable_o (ifid_enable_o),
        .fault_o       (fault_o)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count_o (fetch_count),
        .stall_count_o (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic        e_req;
        logic        e_en;
        logic        e_fault;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " pc_o"},    pc_o, RST);
        chk({tag, " pc4"},     pc_plus4_o, RST + 32'd4);
        chk({tag, " instr"},   instr_o, NOP);
        chk({tag, " valid"},   {31'd0, valid_o}, 32'd0);
        chk({tag, " fault"},   {31'd0, fault_o}, 32'd0);
        chk({tag, " req"},     {31'd0, imem.imem_req_o}, 32'd0);
        chk({tag, " addr"},    imem.imem_addr_o, RST);
        chk({tag, " en"},      {31'd0, ifid_enable_o}, 32'd1);
    endtask

    initial begin
        //          stall redir rpc            rdy  valid instr          pc             addr           req en  fault
        vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, NOP,           RST,           RST,           1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0000, 32'h0040_0000, 32'h0040_0004, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, NOP,           32'h0040_0000, 32'h0040_0004, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, NOP,           32'h0040_0000, 32'h0040_0004, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0004, 32'h0040_0004, 32'h0040_0008, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0008, 32'h0040_0008, 32'h0040_000C, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0008, 32'h0040_0008, 32'h0040_000C, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0008, 32'h0040_0008, 32'h0040_000C, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0008, 32'h0040_0008, 32'h0040_000C, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_000C, 32'h0040_000C, 32'h0040_0010, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'h0040_0100, 1'b1, 1'b0, NOP,           32'h0040_000C, 32'h0040_0100, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0100, 32'h0040_0100, 32'h0040_0104, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0104, 32'h0040_0104, 32'h0040_0108, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, NOP,           32'h0040_0104, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 32'h0040_0102, 1'b1, 1'b0, NOP,           32'h0000_0000, 32'h0040_0102, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 32'h0040_0200, 1'b1, 1'b0, NOP,           32'h0000_0000, 32'h0040_0102, 1'b0, 1'b1, 1'b1};

        reset_n     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem.imem_ready_i = 1'b1;

        @(negedge clk);
        @(negedge clk);
        chk_reset_state("reset");
`ifdef FETCH_PERF_EN
        chk("perf reset fetch", fetch_count, 32'd0);
        chk("perf reset stall", stall_count, 32'd0);
`endif
        reset_n = 1'b1;
        #1;
        chk_reset_state("boot");

        for (int i = 0; i < NV; i++) begin
            stall             = vecs[i].stall;
            redirect          = vecs[i].redir;
            redirect_pc       = vecs[i].rpc;
            imem.imem_ready_i = vecs[i].ready;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i), {31'd0, valid_o}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d instr", i), instr_o, vecs[i].e_instr);
            chk($sformatf("v%0d pc", i), pc_o, vecs[i].e_pc);
            chk($sformatf("v%0d pc4", i), pc_plus4_o, vecs[i].e_pc + 32'd4);
            chk($sformatf("v%0d addr", i), imem.imem_addr_o, vecs[i].e_addr);
            chk($sformatf("v%0d req", i), {31'd0, imem.imem_req_o}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d en", i), {31'd0, ifid_enable_o}, {31'd0, vecs[i].e_en});
            chk($sformatf("v%0d fault", i), {31'd0, fault_o}, {31'd0, vecs[i].e_fault});
            @(negedge clk);
        end

        // Asynchronous reset out of FAULT, mid-cycle
        stall    = 1'b0;
        redirect = 1'b0;
        imem.imem_ready_i = 1'b1;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_state("async_fault");

        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("restart boot valid", {31'd0, valid_o}, 32'd0);
        chk("restart req", {31'd0, imem.imem_req_o}, 32'd1);
        @(posedge clk);
        #1;
        chk("restart instr0", instr_o, RST);
        chk("restart valid0", {31'd0, valid_o}, 32'd1);
        @(posedge clk);
        #1;
        chk("restart instr1", instr_o, RST + 32'd4);

        // Asynchronous reset while running
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_state("async_run");

`ifdef FETCH_PERF_EN
        @(negedge clk);
        reset_n = 1'b1;
        begin
            logic [14:0] ready_pat;
            ready_pat = 15'b110110110110111;
            for (int c = 14; c >= 0; c--) begin
                imem.imem_ready_i = ready_pat[c];
                @(posedge clk);
                #1;
                @(negedge clk);
            end
        end
        chk("perf fetch_count", fetch_count, 32'd10);
        chk("perf stall_count", stall_count, 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction-fetch stage of the RISC-V pipeline: owns the program counter, reads instruction memory through a ready-qualified handshake, and presents {PC, PC+4, instruction, valid} to the IF/ID pipeline register together with that register's enable. It absorbs memory wait states, holds its output while the hazard unit stalls the pipe, flushes on branch/jump redirects from EX, and traps misaligned redirect targets.

## Interface
- N, 32, data/address width
- RESET_PC, 32'h0040_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- stall_i  input  1  hazard unit: hold IF/ID and fetch output
- redirect_i  input  1  one-cycle pulse from EX: taken branch/jump
- redirect_pc_i  input  N  redirect target
- imem_req_o  output  1  fetch request
- imem_addr_o  output  N  fetch address (= PC register)
- imem_ready_i  input  1  imem_rdata_i valid for imem_addr_o this cycle
- imem_rdata_i  input  N  instruction word
- pc_o  output  N  PC of instr_o
- pc_plus4_o  output  N  pc_o + 4
- instr_o  output  N  instruction to IF/ID
- valid_o  output  1  instr_o is a real instruction (0 = bubble)
- ifid_enable_o  output  1  enable for IF/ID register
- fault_o  output  1  sticky misaligned-redirect fault

## Operation
- States: BOOT, RUN, FAULT. Reset -> BOOT; BOOT -> RUN after one cycle; RUN -> FAULT on redirect_i with redirect_pc_i[1:0] != 0; FAULT exits only via reset.
- Reset values: pc register = RESET_PC, pc_o = RESET_PC, pc_plus4_o = RESET_PC+4, instr_o = NOP_INSTR, valid_o = 0, fault_o = 0, state = BOOT.
- imem_req_o = 1 only in RUN; imem_addr_o always = pc register. Reads are side-effect-free; memory may repeat a read for the same address.
- Output buffer "free" when valid_o = 0 or stall_i = 0.
- ifid_enable_o = ~stall_i (combinational), forced 1 in FAULT and BOOT.
- RUN priority per cycle: (1) redirect_i, (2) accept, (3) hold.
- Redirect (aligned): pc <= redirect_pc_i; buffer <= {NOP_INSTR, valid 0}; any imem response this cycle discarded; overrides stall_i.
- Accept: imem_ready_i & buffer free -> buffer <= {pc, pc+4, imem_rdata_i, valid 1}; pc <= pc+4.
- Hold: otherwise buffer unchanged; if buffer free and no ready, valid_o <= 0, instr_o <= NOP_INSTR (wait-state bubble).
- FAULT: imem_req_o = 0, fault_o = 1, buffer forced to bubble, pc frozen at the faulting target.
- Arithmetic: PC increment modulo 2^N; 0xFFFF_FFFC + 4 wraps to 0, no fault.

## Timing
- Zero-wait memory, no stall: one instruction per cycle; fetch address A appears on instr_o the cycle after imem_ready_i.
- First request: cycle after reset deassertion (BOOT); first valid_o the following cycle.
- Redirect: target requested the cycle after redirect_i; first target instruction valid at earliest 2 cycles after redirect_i; exactly one bubble emitted.
- Stall with valid buffer: outputs stable every cycle stall_i is high; memory responses during stall are ignored (address re-presented).
- Async reset mid-operation: all outputs to reset values immediately, independent of clk.

## Configuration
- FETCH_PERF_EN defined: adds outputs fetch_count_o (N) counting accepted instructions and stall_count_o (N) counting cycles in RUN with imem_req_o=1 and no accept; both reset to 0, saturate at all-ones, frozen in FAULT.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset release, imem_ready_i tied 1, rdata = addr: instr_o 0x0040_0000, 0x0040_0004, 0x0040_0008 on consecutive cycles, valid_o=1, pc_plus4_o = pc_o+4.
- imem_ready_i low 2 cycles at 0x0040_0004: two bubbles (valid_o=0, instr_o=0x0000_0013), then 0x0040_0004 valid.
- stall_i high 3 cycles with instr 0x0040_0008 on output: outputs unchanged, ifid_enable_o=0, pc_o stays 0x0040_0008; 0x0040_000C follows release.
- redirect_i with target 0x0040_0100 during stall: next cycle valid_o=0, ifid_enable_o still 0 while stalled; then 0x0040_0100 fetched.
- redirect_i with target 0x0040_0102: fault_o=1, imem_req_o=0 permanently; reset clears fault_o and restarts at 0x0040_0000.
- FETCH_PERF_EN: 10 accepts plus 4 wait cycles -> fetch_count_o=10, stall_count_o=4.
